// File: rtl/jts16_snd_pkg.sv
// ---------------------------------------------------------------------------
// jts16_snd_pkg
// Shared constants for the sound-latch receiver (jts16_snd_rx) and its
// optional FIFO store (jts16_snd_fifo).
//   DEFAULT_DEPTH : buffered entries when the FIFO build is selected
//   IDLE_DOUT     : value shown on dout after reset, before any byte is read
//   LEVEL_W       : width of the pending-byte count presented on level
// ---------------------------------------------------------------------------
package jts16_snd_pkg;

  localparam int         DEFAULT_DEPTH = 4;
  localparam logic [7:0] IDLE_DOUT     = 8'hFF;
  localparam int         LEVEL_W       = 3;

endpackage

// File: rtl/jts16_snd_fifo.sv
// ---------------------------------------------------------------------------
// jts16_snd_fifo
// Circular byte store for the sound latch. Only compiled when the
// JTS16_SNDLATCH_FIFO_EN macro is defined; the single-entry build of
// jts16_snd_rx does not use it.
// Ports:
//   clk_i, rst_i  : clock and synchronous active-high reset
//   push_i, din_i : write request and data (ignored when full unless popping)
//   pop_i         : read request (ignored when empty)
//   head_o        : oldest stored byte
//   full_o        : count equals DEPTH
//   empty_o       : count equals zero
//   count_o       : number of stored bytes
// ---------------------------------------------------------------------------
`ifdef JTS16_SNDLATCH_FIFO_EN
module jts16_snd_fifo
  import jts16_snd_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [7:0]             din_i,
  output logic [7:0]             head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // A pop frees the head slot in the same cycle, so a push into a full store
  // is still accepted when it coincides with a pop.
  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != FULL_CNT) | do_pop);

  // Pointers are AW bits wide, so natural overflow wraps them modulo DEPTH.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PTR_ONE;
    if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once it has been pushed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule
`endif

// File: rtl/jts16_snd_rx.sv
// ---------------------------------------------------------------------------
// jts16_snd_rx
// Sound-CPU side of the main-to-sound command latch. A falling edge on the
// main CPU's snd_irqn captures snd_latch; the sound CPU reads it with rd and
// is interrupted through nmi_n while anything is pending.
// Build option: define JTS16_SNDLATCH_FIFO_EN for a DEPTH-entry FIFO that
// drops bytes on overrun; otherwise a single entry that is overwritten.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   snd_latch  : command byte from the main CPU
//   snd_irqn   : main-CPU request, active low, falling edge captures
//   snd_ack    : high when nothing is pending
//   rd         : sound-CPU read strobe, one clk wide
//   dout       : oldest unread byte (last consumed byte when empty)
//   nmi_n      : sound-CPU NMI request, active low while bytes are pending
//   ovf        : sticky overrun flag, cleared only by reset
//   level      : number of pending bytes
// ---------------------------------------------------------------------------
module jts16_snd_rx
  import jts16_snd_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         snd_latch,
  input  logic               snd_irqn,
  output logic               snd_ack,
  input  logic               rd,
  output logic [7:0]         dout,
  output logic               nmi_n,
  output logic               ovf,
  output logic [LEVEL_W-1:0] level
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("jts16_snd_rx: DEPTH must be a power of two and at least 2");
  end

  logic irqn_q;
  logic ovf_q, ovf_d;
  logic capture;
  logic overrun;

  // irqn_q resets high so a request already low when reset drops is still
  // seen as a fresh falling edge in the first cycle after reset.
  assign capture = irqn_q & ~snd_irqn;
  assign ovf_d   = ovf_q | overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      irqn_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      irqn_q <= snd_irqn;
      ovf_q  <= ovf_d;
    end
  end

`ifdef JTS16_SNDLATCH_FIFO_EN
  localparam int CW = $clog2(DEPTH) + 1;

  logic          fifo_full, fifo_empty;
  logic          pop;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic [7:0]    last_q, last_d;

  // A read against a full FIFO frees a slot first, so only a capture with no
  // read counts as an overrun; the new byte is then dropped by the FIFO.
  assign pop     = rd & ~fifo_empty;
  assign overrun = capture & fifo_full & ~rd;
  assign last_d  = pop ? head : last_q;

  jts16_snd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (capture),
    .pop_i   (pop),
    .din_i   (snd_latch),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  // When empty, dout keeps showing the byte the sound CPU read last.
  always_ff @(posedge clk) begin
    if (rst) last_q <= IDLE_DOUT;
    else     last_q <= last_d;
  end

  assign dout  = fifo_empty ? last_q : head;
  assign level = LEVEL_W'(count);
`else
  logic [7:0] data_q, data_d;
  logic       full_q, full_d;

  // The read is applied before the capture, so a capture in the same cycle
  // as a read always leaves exactly one byte pending.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (rd) full_d = 1'b0;
    if (capture) begin
      data_d = snd_latch;
      full_d = 1'b1;
    end
  end

  assign overrun = capture & full_q & ~rd;

  // data_q is never cleared by a read, so it doubles as the last-read byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= IDLE_DOUT;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign dout  = data_q;
  assign level = LEVEL_W'(full_q);
`endif

  assign nmi_n   = (level == '0);
  assign snd_ack = (level == '0);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_jts16_snd_rx.sv
// ---------------------------------------------------------------------------
// tb_jts16_snd_rx
// Self-checking bench for jts16_snd_rx. Every driven cycle updates a queue
// based reference model and pushes the expected outputs into a scoreboard;
// a monitor on the falling clock edge pops and compares. Directed checks for
// the documented scenarios are layered on top. Build with or without
// JTS16_SNDLATCH_FIFO_EN to match the DUT build.
// ---------------------------------------------------------------------------
module tb_jts16_snd_rx;

  localparam int DEPTH = 4;
`ifdef JTS16_SNDLATCH_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] snd_latch;
  logic       snd_irqn;
  logic       snd_ack;
  logic       rd;
  logic [7:0] dout;
  logic       nmi_n;
  logic       ovf;
  logic [2:0] level;

  typedef struct {
    logic [7:0] dout;
    logic [2:0] level;
    logic       nmi_n;
    logic       ack;
    logic       ovf;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] modelQ[$];
  logic [7:0] lastByte;
  bit         modelOvf;
  bit         prevIrqn;

  int assertCount = 0;
  int failCount   = 0;

  jts16_snd_rx #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .snd_latch (snd_latch),
    .snd_irqn  (snd_irqn),
    .snd_ack   (snd_ack),
    .rd        (rd),
    .dout      (dout),
    .nmi_n     (nmi_n),
    .ovf       (ovf),
    .level     (level)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison, counted and reported on mismatch.
  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one clock cycle of inputs, advances the reference model the way
  // the block is described to behave, and queues the outputs expected after
  // the coming rising edge.
  task automatic applyStimulus(input logic irqnV, input logic [7:0] latchV,
                               input logic rdV, input logic rstV);
    exp_t e;
    bit   cap;
    snd_irqn  = irqnV;
    snd_latch = latchV;
    rd        = rdV;
    rst       = rstV;
    if (rstV) begin
      modelQ.delete();
      lastByte = 8'hFF;
      modelOvf = 1'b0;
      prevIrqn = 1'b1;
    end else begin
      cap = prevIrqn && !irqnV;
      if (rdV && modelQ.size() > 0) lastByte = modelQ.pop_front();
      if (cap) begin
        if (modelQ.size() < CAP) begin
          modelQ.push_back(latchV);
        end else begin
          modelOvf = 1'b1;
          if (CAP == 1) modelQ[0] = latchV;
        end
      end
      prevIrqn = irqnV;
    end
    e.dout  = (modelQ.size() > 0) ? modelQ[0] : lastByte;
    e.level = 3'(modelQ.size());
    e.nmi_n = (modelQ.size() == 0);
    e.ack   = (modelQ.size() == 0);
    e.ovf   = modelOvf;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: outputs are sampled mid-cycle, away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("sb dout",  dout,    e.dout);
      checkOutput("sb level", level,   e.level);
      checkOutput("sb nmi_n", nmi_n,   e.nmi_n);
      checkOutput("sb ack",   snd_ack, e.ack);
      checkOutput("sb ovf",   ovf,     e.ovf);
    end
  end

  // Guards against a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] firstHeld;
    snd_irqn  = 1'b1;
    snd_latch = 8'h00;
    rd        = 1'b0;
    rst       = 1'b1;

    // Reset for cycles 0..2, idle up to cycle 9, capture 8'h5A at cycle 10.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
    idleCycles(7);
    applyStimulus(1'b0, 8'h5A, 1'b0, 1'b0);
    checkOutput("cap dout",  dout,    8'h5A);
    checkOutput("cap level", level,   8'd1);
    checkOutput("cap nmi_n", nmi_n,   8'd0);
    checkOutput("cap ack",   snd_ack, 8'd0);

    // Read it back; the rising snd_irqn in the same cycle must do nothing.
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
    checkOutput("rd level", level,   8'd0);
    checkOutput("rd nmi_n", nmi_n,   8'd1);
    checkOutput("rd ack",   snd_ack, 8'd1);
    checkOutput("rd dout",  dout,    8'h5A);

    // Two captures without a read.
    applyStimulus(1'b0, 8'h11, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 8'h22, 1'b0, 1'b0);
`ifdef JTS16_SNDLATCH_FIFO_EN
    checkOutput("two level", level, 8'd2);
    checkOutput("two ovf",   ovf,   8'd0);
    checkOutput("two head",  dout,  8'h11);
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
    checkOutput("two rd1 dout", dout, 8'h22);
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
    checkOutput("two rd2 dout",  dout,  8'h22);
    checkOutput("two rd2 level", level, 8'd0);
`else
    checkOutput("two dout",  dout,  8'h22);
    checkOutput("two ovf",   ovf,   8'd1);
    checkOutput("two level", level, 8'd1);
    idleCycles(1);
`endif
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
    idleCycles(1);

`ifdef JTS16_SNDLATCH_FIFO_EN
    // Five captures into a four-entry FIFO: the fifth is dropped.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 8'(i), 1'b0, 1'b0);
      idleCycles(1);
    end
    checkOutput("full level", level, 8'd4);
    checkOutput("full ovf",   ovf,   8'd1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("full read", dout, 8'(i));
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("full drained", level, 8'd0);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
    idleCycles(1);
`endif

    // Simultaneous capture and read with one byte pending.
    applyStimulus(1'b0, 8'hA0, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("sim pre dout", dout, 8'hA0);
    applyStimulus(1'b0, 8'hB0, 1'b1, 1'b0);
    checkOutput("sim level", level, 8'd1);
    checkOutput("sim dout",  dout,  8'hB0);
    checkOutput("sim nmi_n", nmi_n, 8'd0);
    checkOutput("sim ovf",   ovf,   8'd0);
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
    checkOutput("sim drain", level, 8'd0);

    // Hold snd_irqn low for 20 cycles: exactly one capture, then reset.
    firstHeld = 8'h31;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'(8'h31 + i), 1'b0, 1'b0);
    checkOutput("hold level", level, 8'd1);
    checkOutput("hold dout",  dout,  firstHeld);
    applyStimulus(1'b0, 8'h77, 1'b0, 1'b1);
    checkOutput("rst dout",  dout,    8'hFF);
    checkOutput("rst level", level,   8'd0);
    checkOutput("rst nmi_n", nmi_n,   8'd1);
    checkOutput("rst ack",   snd_ack, 8'd1);
    checkOutput("rst ovf",   ovf,     8'd0);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("post rst level", level, 8'd0);

    // Random traffic: slow reader first to reach overruns, then fast reader.
    for (int i = 0; i < 800; i++) begin
      logic irqnV, rdV, rstV;
      irqnV = ($urandom_range(0, 2) != 0);
      rdV   = (i < 400) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      rstV  = ($urandom_range(0, 149) == 0);
      applyStimulus(irqnV, 8'($urandom), rdV, rstV);
    end

    idleCycles(2);
    @(negedge clk);
    #1;
    checkOutput("sb drained", 8'(expQ.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
